parser_mem_arbiter: RTL and testbench

PARSER_MEM_ARBITER -- requirements
Module: parser_mem_arbiter

---
 rtl/parser_includes.sv | 11 +
 rtl/parser_typedefs_pkg.sv | 26 ++
 rtl/rr_pick.sv | 36 +++
 rtl/parser_mem_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_parser_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/parser_includes.sv
// -----------------------------------------------------------------------------
// parser_includes
// Bus geometry shared by the parser blocks. The parser moves BUS_WIDTH_B
// bytes per word, each BYTE_WIDTH bits wide.
// -----------------------------------------------------------------------------
package parser_includes;

  localparam int BUS_WIDTH_B = 4;
  localparam int BYTE_WIDTH  = 8;

endpackage : parser_includes

// File: rtl/parser_typedefs_pkg.sv
// -----------------------------------------------------------------------------
// parser_typedefs_pkg
// Shared types and defaults for the parser payload-memory arbiter.
//   ARB_STATES      : arbiter FSM encoding (idle / locked on a packet / done)
//   ARB_TIMEOUT_DEF : idle cycles tolerated inside a locked packet
//   ARB_DATA_W_DEF  : default memory word width (bus bytes * byte width)
//   arb_idx_w       : width of a requester index for n requesters (min 1)
// -----------------------------------------------------------------------------
package parser_typedefs_pkg;

  import parser_includes::*;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_LOCK = 2'd1,
    ARB_DONE = 2'd2
  } ARB_STATES;

  localparam int ARB_TIMEOUT_DEF = 64;
  localparam int ARB_DATA_W_DEF  = BUS_WIDTH_B * BYTE_WIDTH;

  function automatic int arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : parser_typedefs_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search: returns the first set bit of req at or
// after position ptr, wrapping from N-1 back to 0.
//   req   : request vector, N bits
//   ptr   : search start position
//   found : at least one request bit is set
//   idx   : index of the selected request (0 when found=0)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Walk the offsets from the far end down to zero so the last hit written
  // is the one nearest to ptr.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule : rr_pick

// File: rtl/parser_mem_arbiter.sv
// -----------------------------------------------------------------------------
// parser_mem_arbiter
// Merges N_REQ parser write streams into one payload-memory write port.
// A requester is granted for a whole packet (until it presents a word with
// req_last, or until it stays silent for TIMEOUT cycles). Words are written to
// consecutive addresses from a pointer that persists across packets.
//
// Ports
//   CLK, reset        : clock; synchronous active-high reset
//   req_valid[N_REQ]  : per-parser word valid
//   req_data          : per-parser words, requester i at [i*DATA_W +: DATA_W]
//   req_last[N_REQ]   : word is the final word of its packet
//   req_ready[N_REQ]  : per-parser accept (only the granted parser can see 1)
//   mem_out           : registered word to memory
//   mem_addr          : registered word address
//   mem_w_valid       : registered write valid
//   mem_w_ready       : memory accept
//   pkt_done          : one-cycle packet completion pulse
//   pkt_src           : id of the requester whose packet finished
//   pkt_words         : words accepted in that packet (saturating)
//   pkt_err           : packet ended by idle timeout rather than req_last
//   dbg_state         : current arbiter state
//
// Handshakes: every interface transfers on a clock edge where valid && ready
// are both 1; valid may not wait for ready, and a raised valid (with its data)
// holds until that transfer. mem_w_valid / mem_out / mem_addr follow this on
// the memory side; req_valid / req_data / req_last on each parser side.
// -----------------------------------------------------------------------------
module parser_mem_arbiter
  import parser_typedefs_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = ARB_DATA_W_DEF,
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic                                    CLK,
  input  logic                                    reset,
  input  logic [N_REQ-1:0]                        req_valid,
  input  logic [N_REQ*DATA_W-1:0]                 req_data,
  input  logic [N_REQ-1:0]                        req_last,
  output logic [N_REQ-1:0]                        req_ready,
  output logic [DATA_W-1:0]                       mem_out,
  output logic [ADDR_W-1:0]                       mem_addr,
  output logic                                    mem_w_valid,
  input  logic                                    mem_w_ready,
  output logic                                    pkt_done,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] pkt_src,
  output logic [ADDR_W:0]                         pkt_words,
  output logic                                    pkt_err,
  output ARB_STATES                               dbg_state
);

  localparam int IW     = arb_idx_w(N_REQ);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ARB_STATES           state_q, state_d;
  logic [IW-1:0]       grant_q, grant_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     word_ctr_q, word_ctr_d;
  logic [IDLE_W-1:0]   idle_ctr_q, idle_ctr_d;
  logic [DATA_W-1:0]   mem_out_q, mem_out_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_w_valid_q, mem_w_valid_d;
  logic                pkt_done_q, pkt_done_d;
  logic [IW-1:0]       pkt_src_q, pkt_src_d;
  logic [ADDR_W:0]     pkt_words_q, pkt_words_d;
  logic                pkt_err_q, pkt_err_d;

  // ---------------------------------------------------------------------------
  // Granted-requester view
  // ---------------------------------------------------------------------------
  logic              lock;
  logic              mem_free;
  logic              g_valid;
  logic              g_last;
  logic [DATA_W-1:0] g_data;
  logic              accept;
  logic [ADDR_W:0]   word_ctr_inc;
  logic [IDLE_W-1:0] idle_inc;
  logic [IW-1:0]     grant_next;
  logic              pick_found;
  logic [IW-1:0]     pick_idx;

  assign lock     = (state_q == ARB_LOCK);
  // The output register can take a new word when it is empty or draining.
  assign mem_free = !mem_w_valid_q || mem_w_ready;
  assign g_valid  = req_valid[grant_q];
  assign g_last   = req_last[grant_q];
  assign g_data   = req_data[int'(grant_q)*DATA_W +: DATA_W];
  assign accept   = lock && mem_free && g_valid;

  // Saturating packet word count.
  assign word_ctr_inc = (&word_ctr_q) ? word_ctr_q : word_ctr_q + 1'b1;
  assign idle_inc     = idle_ctr_q + 1'b1;
  // Round-robin restarts just past the requester that finished.
  assign grant_next   = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    req_ready = '0;
    if (lock && mem_free) req_ready[grant_q] = 1'b1;
  end

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    word_ctr_d    = word_ctr_q;
    idle_ctr_d    = idle_ctr_q;
    mem_out_d     = mem_out_q;
    mem_addr_d    = mem_addr_q;
    mem_w_valid_d = mem_w_valid_q;
    pkt_done_d    = 1'b0;
    pkt_src_d     = pkt_src_q;
    pkt_words_d   = pkt_words_q;
    pkt_err_d     = pkt_err_q;

    // Memory-side register: retire on handshake, reload on accept. The
    // register keeps draining independently of the FSM, so a pending write
    // never holds up the return to idle.
    if (mem_w_valid_q && mem_w_ready) mem_w_valid_d = 1'b0;
    if (accept) begin
      mem_out_d     = g_data;
      mem_addr_d    = wr_ptr_q;
      mem_w_valid_d = 1'b1;
    end

    case (state_q)
      ARB_IDLE: begin
        // Grant is registered; the granted requester is served from the
        // following cycle.
        if (pick_found) begin
          grant_d    = pick_idx;
          word_ctr_d = '0;
          idle_ctr_d = '0;
          state_d    = ARB_LOCK;
        end
      end

      ARB_LOCK: begin
        if (accept) begin
          wr_ptr_d   = wr_ptr_q + 1'b1;
          word_ctr_d = word_ctr_inc;
          idle_ctr_d = '0;
          if (g_last) begin
            state_d     = ARB_DONE;
            rr_ptr_d    = grant_next;
            pkt_done_d  = 1'b1;
            pkt_src_d   = grant_q;
            pkt_words_d = word_ctr_inc;
            pkt_err_d   = 1'b0;
          end
        end else if (!g_valid) begin
          idle_ctr_d = idle_inc;
          if (idle_inc == IDLE_W'(TIMEOUT)) begin
            state_d     = ARB_DONE;
            rr_ptr_d    = grant_next;
            pkt_done_d  = 1'b1;
            pkt_src_d   = grant_q;
            pkt_words_d = word_ctr_q;
            pkt_err_d   = 1'b1;
          end
        end else begin
          // Valid but held off by memory back-pressure: the requester is not
          // silent, so the idle run is broken.
          idle_ctr_d = '0;
        end
      end

      ARB_DONE: state_d = ARB_IDLE;

      default: state_d = ARB_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      word_ctr_q    <= '0;
      idle_ctr_q    <= '0;
      mem_out_q     <= '0;
      mem_addr_q    <= '0;
      mem_w_valid_q <= 1'b0;
      pkt_done_q    <= 1'b0;
      pkt_src_q     <= '0;
      pkt_words_q   <= '0;
      pkt_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      word_ctr_q    <= word_ctr_d;
      idle_ctr_q    <= idle_ctr_d;
      mem_out_q     <= mem_out_d;
      mem_addr_q    <= mem_addr_d;
      mem_w_valid_q <= mem_w_valid_d;
      pkt_done_q    <= pkt_done_d;
      pkt_src_q     <= pkt_src_d;
      pkt_words_q   <= pkt_words_d;
      pkt_err_q     <= pkt_err_d;
    end
  end

  assign mem_out     = mem_out_q;
  assign mem_addr    = mem_addr_q;
  assign mem_w_valid = mem_w_valid_q;
  assign pkt_done    = pkt_done_q;
  assign pkt_src     = pkt_src_q;
  assign pkt_words   = pkt_words_q;
  assign pkt_err     = pkt_err_q;
  assign dbg_state   = state_q;

endmodule : parser_mem_arbiter

// File: tb/tb_parser_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_parser_mem_arbiter
// Directed bench for parser_mem_arbiter. Each parser is a word queue served by
// a driver; the expected memory write stream (address, data) and packet
// completions are queued in the order the packets must be served, with
// addresses from a simple running counter. A negedge monitor compares every
// memory handshake and every pkt_done pulse against those queues and checks
// hold/ready rules; tests add literal checks on logged addresses and timing.
// -----------------------------------------------------------------------------
module tb_parser_mem_arbiter;
  import parser_typedefs_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int TO = 64;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic            CLK = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   mem_out;
  logic [AW-1:0]   mem_addr;
  logic            mem_w_valid;
  logic            mem_w_ready = 1'b1;
  logic            pkt_done;
  logic [1:0]      pkt_src;
  logic [AW:0]     pkt_words;
  logic            pkt_err;
  ARB_STATES       dbg_state;

  always #5 CLK = ~CLK;

  parser_mem_arbiter #(
    .N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .mem_out(mem_out), .mem_addr(mem_addr), .mem_w_valid(mem_w_valid),
    .mem_w_ready(mem_w_ready),
    .pkt_done(pkt_done), .pkt_src(pkt_src), .pkt_words(pkt_words),
    .pkt_err(pkt_err), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  logic [32:0] src_q [N][$];     // {last, data} per parser
  logic [43:0] exp_q [$];        // {addr, data} expected memory writes
  logic [15:0] exp_p_q [$];      // {src[1:0], words[12:0], err}
  int          model_wr = 0;     // next expected write address

  logic [AW-1:0] log_addr [$];
  logic [DW-1:0] log_data [$];
  int            log_cyc  [$];
  int            pkt_cyc  [$];

  logic [N-1:0]  acc_s = '0;     // requesters that transfer at the next edge
  logic          prev_stall = 1'b0;
  logic [DW-1:0] p_out;
  logic [AW-1:0] p_addr;
  logic [43:0]   e;
  logic [15:0]   ep;

  task automatic check(input bit ok, input string name,
                       input longint act, input longint exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [DW-1:0] mk(input int src, input int tag, input int idx);
    return {8'(src), 8'(tag), 16'(idx)};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send_pkt(input int src, input int tag, input int n, input bit with_last);
    for (int i = 0; i < n; i++)
      src_q[src].push_back({with_last && (i == n - 1), mk(src, tag, i)});
  endtask

  task automatic expect_words(input int src, input int tag, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({12'(model_wr), mk(src, tag, i)});
      model_wr = (model_wr + 1) % (1 << AW);
    end
  endtask

  task automatic expect_done(input int src, input int words, input bit err);
    exp_p_q.push_back({2'(src), 13'(words), err});
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k = 0;
    while ((exp_q.size() != 0 || exp_p_q.size() != 0) && k < budget) begin
      @(negedge CLK); #1;
      k++;
    end
    check(exp_q.size() == 0 && exp_p_q.size() == 0, name,
          exp_q.size() + exp_p_q.size(), 0);
  endtask

  task automatic wait_log(input int target, input int budget, input string name);
    int k = 0;
    while (log_addr.size() < target && k < budget) begin
      @(negedge CLK); #1;
      k++;
    end
    check(log_addr.size() >= target, name, log_addr.size(), target);
  endtask

  // Parser model: present the head word, drop it after it transfers.
  initial begin
    forever begin
      @(posedge CLK); #1;
      for (int i = 0; i < N; i++) begin
        if (acc_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          req_valid[i]           = 1'b1;
          req_last[i]            = src_q[i][0][32];
          req_data[i*DW +: DW]   = src_q[i][0][31:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard / monitor
  // ---------------------------------------------------------------------------
  always @(negedge CLK) begin
    cyc++;
    if (reset) begin
      prev_stall = 1'b0;
      acc_s      = '0;
    end else begin
      if (prev_stall) begin
        check(mem_w_valid == 1'b1, "stall_valid_hold", mem_w_valid, 1);
        check(mem_out == p_out, "stall_data_hold", mem_out, p_out);
        check(mem_addr == p_addr, "stall_addr_hold", mem_addr, p_addr);
      end
      if (mem_w_valid && !mem_w_ready)
        check(req_ready == '0, "stall_ready_low", req_ready, 0);
      check($countones(req_ready) <= 1, "ready_single", req_ready, 0);

      if (mem_w_valid && mem_w_ready) begin
        log_addr.push_back(mem_addr);
        log_data.push_back(mem_out);
        log_cyc.push_back(cyc);
        check(exp_q.size() > 0, "write_expected", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check(mem_out == e[31:0], "wr_data", mem_out, e[31:0]);
          check(mem_addr == e[43:32], "wr_addr", mem_addr, e[43:32]);
        end
      end

      if (pkt_done) begin
        pkt_cyc.push_back(cyc);
        check(exp_p_q.size() > 0, "pkt_expected", exp_p_q.size(), 1);
        if (exp_p_q.size() > 0) begin
          ep = exp_p_q.pop_front();
          check(pkt_src == ep[15:14], "pkt_src", pkt_src, ep[15:14]);
          check(pkt_words == ep[13:1], "pkt_words", pkt_words, ep[13:1]);
          check(pkt_err == ep[0], "pkt_err", pkt_err, ep[0]);
        end
      end

      prev_stall = mem_w_valid && !mem_w_ready;
      p_out      = mem_out;
      p_addr     = mem_addr;
      acc_s      = req_valid & req_ready;
    end
  end

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic check_reset_outputs(input string tag);
    check(req_ready == '0,      {tag, "_req_ready"}, req_ready, 0);
    check(mem_w_valid == 1'b0,  {tag, "_mem_w_valid"}, mem_w_valid, 0);
    check(mem_out == '0,        {tag, "_mem_out"}, mem_out, 0);
    check(mem_addr == '0,       {tag, "_mem_addr"}, mem_addr, 0);
    check(pkt_done == 1'b0,     {tag, "_pkt_done"}, pkt_done, 0);
    check(pkt_src == '0,        {tag, "_pkt_src"}, pkt_src, 0);
    check(pkt_words == '0,      {tag, "_pkt_words"}, pkt_words, 0);
    check(pkt_err == 1'b0,      {tag, "_pkt_err"}, pkt_err, 0);
    check(dbg_state == ARB_IDLE, {tag, "_state"}, dbg_state, ARB_IDLE);
  endtask

  initial begin
    int b;
    int pb;
    int n;

    // Reset values
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    check_reset_outputs("rst");
    reset = 1'b0;

    // Single packet from requester 0
    b = log_addr.size(); pb = pkt_cyc.size();
    send_pkt(0, 1, 3, 1);
    expect_words(0, 1, 3);
    expect_done(0, 3, 0);
    wait_drain(50, "t1_drain");
    for (int i = 0; i < 3; i++)
      check(log_addr[b+i] == 12'(i), "t1_addr", log_addr[b+i], i);
    check(log_cyc[b+2] - log_cyc[b] == 2, "t1_throughput", log_cyc[b+2] - log_cyc[b], 2);
    check(pkt_cyc[pb] == log_cyc[b+2], "t1_done_timing", pkt_cyc[pb], log_cyc[b+2]);

    // Requester 3 leaves the pointer at 0, then 1 and 2 contend
    send_pkt(3, 2, 2, 1);
    expect_words(3, 2, 2);
    expect_done(3, 2, 0);
    wait_drain(50, "t2a_drain");
    b = log_addr.size();
    send_pkt(1, 3, 3, 1);
    send_pkt(2, 4, 2, 1);
    expect_words(1, 3, 3);
    expect_done(1, 3, 0);
    expect_words(2, 4, 2);
    expect_done(2, 2, 0);
    wait_drain(80, "t2b_drain");
    for (int i = 0; i < 5; i++)
      check(log_data[b+i][31:24] == ((i < 3) ? 8'd1 : 8'd2), "t2_order",
            log_data[b+i][31:24], (i < 3) ? 1 : 2);

    // Memory back-pressure for 5 cycles mid-packet
    send_pkt(0, 5, 6, 1);
    expect_words(0, 5, 6);
    expect_done(0, 6, 0);
    b = log_addr.size();
    wait_log(b + 2, 50, "t3_start");
    @(posedge CLK); #1;
    mem_w_ready = 1'b0;
    repeat (5) begin
      @(negedge CLK); #1;
      check(req_ready == '0, "t3_ready_low", req_ready, 0);
      check(mem_w_valid == 1'b1, "t3_valid_held", mem_w_valid, 1);
    end
    @(posedge CLK); #1;
    mem_w_ready = 1'b1;
    wait_drain(80, "t3_drain");

    // Requester 1 goes silent; requester 2 waits for the timeout
    b = log_addr.size(); pb = pkt_cyc.size();
    send_pkt(1, 6, 2, 0);
    send_pkt(2, 7, 2, 1);
    expect_words(1, 6, 2);
    expect_done(1, 2, 1);
    expect_words(2, 7, 2);
    expect_done(2, 2, 0);
    wait_drain(300, "t4_drain");
    check(pkt_cyc[pb] - log_cyc[b+1] == TO, "t4_timeout_len", pkt_cyc[pb] - log_cyc[b+1], TO);

    // Walk the write pointer to 4094, then cross the wrap
    n = 4094 - model_wr;
    send_pkt(3, 8, n, 1);
    expect_words(3, 8, n);
    expect_done(3, n, 0);
    wait_drain(n + 100, "t5a_drain");
    b = log_addr.size();
    send_pkt(0, 9, 4, 1);
    expect_words(0, 9, 4);
    expect_done(0, 4, 0);
    wait_drain(50, "t5b_drain");
    check(log_addr[b]   == 12'd4094, "t5_addr0", log_addr[b],   4094);
    check(log_addr[b+1] == 12'd4095, "t5_addr1", log_addr[b+1], 4095);
    check(log_addr[b+2] == 12'd0,    "t5_addr2", log_addr[b+2], 0);
    check(log_addr[b+3] == 12'd1,    "t5_addr3", log_addr[b+3], 1);

    // Reset while the second word is being offered
    b = log_addr.size(); pb = pkt_cyc.size();
    send_pkt(1, 10, 4, 1);
    expect_words(1, 10, 4);
    expect_done(1, 4, 0);
    wait_log(b + 1, 50, "t6_first_word");
    reset = 1'b1;
    src_q[1].delete();
    exp_q.delete();
    exp_p_q.delete();
    model_wr = 0;
    @(negedge CLK); #1;
    check_reset_outputs("t6_rst");
    @(negedge CLK); #1;
    reset = 1'b0;
    check(pkt_cyc.size() == pb, "t6_no_done", pkt_cyc.size(), pb);
    b = log_addr.size();
    send_pkt(2, 11, 2, 1);
    expect_words(2, 11, 2);
    expect_done(2, 2, 0);
    wait_drain(50, "t6_drain");
    check(log_addr[b] == 12'd0, "t6_addr0", log_addr[b], 0);
    check(log_addr[b+1] == 12'd1, "t6_addr1", log_addr[b+1], 1);
    check(log_data[b] == 32'h020B_0000, "t6_data0", log_data[b], 32'h020B_0000);

    // Final state
    repeat (3) @(negedge CLK);
    #1;
    check(exp_q.size() == 0, "end_writes", exp_q.size(), 0);
    check(exp_p_q.size() == 0, "end_pkts", exp_p_q.size(), 0);
    for (int i = 0; i < N; i++)
      check(src_q[i].size() == 0, "end_src", src_q[i].size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_parser_mem_arbiter
